trigger_register: RTL and testbench

//   WIDTH-bit register built as a bank of T/D triggers, selectable per cycle as:

---
 rtl/trigger_register.sv | 93 +++++++++
 tb/tb_trigger_register.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_register.sv
// WIDTH-bit register built from T/D trigger cells: hold, load, masked toggle,
// up/down count, shift left/right and clear, selected per clock edge.
//
// Ports:
//   Clock    rising-edge clock
//   Reset_n  synchronous active-low reset (Q <= RESET_VAL)
//   En       clock enable; 0 holds Q and Ser_out, drops Carry
//   Mode     operation select (HOLD/LOAD/TOGGLE/UP/DOWN/SHL/SHR/CLEAR)
//   D        parallel load data
//   T        toggle mask, bit i = 1 flips Q[i]
//   Ser_in   serial input for shift modes
//   Q        register state
//   Q_inv    bitwise complement of Q
//   Carry    one-cycle pulse when the counter wraps in either direction
//   Ser_out  bit shifted out by the most recent shift
module trigger_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] T,
    input  logic             Ser_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_inv,
    output logic             Carry,
    output logic             Ser_out
);

    typedef enum logic [2:0] {
        M_HOLD   = 3'b000,
        M_LOAD   = 3'b001,
        M_TOGGLE = 3'b010,
        M_UP     = 3'b011,
        M_DOWN   = 3'b100,
        M_SHL    = 3'b101,
        M_SHR    = 3'b110,
        M_CLEAR  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Complement is derived from Q so both always change on the same edge.
    assign Q_inv = ~Q;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Q       <= RESET_VAL;
            Carry   <= 1'b0;
            Ser_out <= 1'b0;
        end else if (!En) begin
            Carry <= 1'b0;
        end else begin
            // Carry is a pulse: any edge that is not a wrap clears it.
            Carry <= 1'b0;
            unique case (mode_t'(Mode))
                M_HOLD: begin
                    Q <= Q;
                end
                M_LOAD: begin
                    Q <= D;
                end
                M_TOGGLE: begin
                    Q <= Q ^ T;
                end
                M_UP: begin
                    Q     <= Q + ONE;
                    Carry <= (Q == ALL_ONES);
                end
                M_DOWN: begin
                    Q     <= Q - ONE;
                    Carry <= (Q == '0);
                end
                M_SHL: begin
                    Q       <= {Q[WIDTH-2:0], Ser_in};
                    Ser_out <= Q[WIDTH-1];
                end
                M_SHR: begin
                    Q       <= {Ser_in, Q[WIDTH-1:1]};
                    Ser_out <= Q[0];
                end
                M_CLEAR: begin
                    Q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_register.sv
// Self-checking bench for trigger_register: directed vector table,
// hand-written corner sequences, and random stimulus against a reference model.
`timescale 1us/1ns
module tb_trigger_register;

    logic       Clock = 1'b0;
    logic       Reset_n, En, Ser_in;
    logic [2:0] Mode;
    logic [3:0] D, T, Q, Q_inv;
    logic       Carry, Ser_out;

    logic       rst2;
    logic [1:0] q2, q2_inv;
    logic       carry2, so2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int qm, cm, sm;

    // 1 kHz clock
    always #500 Clock = ~Clock;

    trigger_register #(.WIDTH(4), .RESET_VAL(4'h5)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .En(En), .Mode(Mode),
        .D(D), .T(T), .Ser_in(Ser_in),
        .Q(Q), .Q_inv(Q_inv), .Carry(Carry), .Ser_out(Ser_out)
    );

    trigger_register #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
        .Clock(Clock), .Reset_n(rst2), .En(1'b1), .Mode(3'b010),
        .D(2'b00), .T(2'b01), .Ser_in(1'b0),
        .Q(q2), .Q_inv(q2_inv), .Carry(carry2), .Ser_out(so2)
    );

    always @(posedge Clock) begin
        if (En === 1'b1 && $isunknown(Mode)) begin
            vectors++;
            miscompares++;
            $display("FAIL mode_x: Mode=%b while En=1, required known", Mode);
        end
    end

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] mode;
        logic [3:0] d;
        logic [3:0] t;
        logic       ser;
        logic [3:0] q;
        logic       carry;
        logic       so;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Model written from the operation rules in plain integer arithmetic.
    task automatic model();
        if (!Reset_n) begin
            qm = 5; cm = 0; sm = 0;
        end else begin
            cm = 0;
            if (En) begin
                case (Mode)
                    3'd1: qm = D;
                    3'd2: qm = qm ^ T;
                    3'd3: begin cm = (qm == 15); qm = (qm + 1) % 16; end
                    3'd4: begin cm = (qm == 0); qm = (qm + 15) % 16; end
                    3'd5: begin sm = qm / 8; qm = (qm * 2) % 16 + Ser_in; end
                    3'd6: begin sm = qm % 2; qm = qm / 2 + Ser_in * 8; end
                    3'd7: qm = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        model();
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [3:0] d, input logic [3:0] t, input logic s);
        Reset_n = r; En = e; Mode = m; D = d; T = t; Ser_in = s;
    endtask

    task automatic add(input logic r, input logic e, input logic [2:0] m,
                       input logic [3:0] d, input logic [3:0] t, input logic s,
                       input logic [3:0] q, input logic c, input logic so);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.d = d; v.t = t; v.ser = s;
        v.q = q; v.carry = c; v.so = so;
        tbl.push_back(v);
    endtask

    initial begin
        rst2 = 1'b0;
        drive(1'b0, 1'b1, 3'd3, 4'h0, 4'h0, 1'b0);

        // reset with UP requested
        add(0, 1, 3'd3, 4'h0, 4'h0, 0, 4'h5, 0, 0);
        add(0, 1, 3'd3, 4'h0, 4'h0, 0, 4'h5, 0, 0);
        // count wrap
        add(1, 1, 3'd1, 4'hE, 4'h0, 0, 4'hE, 0, 0);
        add(1, 1, 3'd3, 4'h0, 4'h0, 0, 4'hF, 0, 0);
        add(1, 1, 3'd3, 4'h0, 4'h0, 0, 4'h0, 1, 0);
        add(1, 1, 3'd3, 4'h0, 4'h0, 0, 4'h1, 0, 0);
        add(1, 1, 3'd1, 4'h0, 4'h0, 0, 4'h0, 0, 0);
        add(1, 1, 3'd4, 4'h0, 4'h0, 0, 4'hF, 1, 0);
        // toggle mask
        add(1, 1, 3'd1, 4'h5, 4'h0, 0, 4'h5, 0, 0);
        add(1, 1, 3'd2, 4'h0, 4'h9, 0, 4'hC, 0, 0);
        add(1, 1, 3'd2, 4'h0, 4'h0, 0, 4'hC, 0, 0);
        // shift, with Ser_out holding across a HOLD
        add(1, 1, 3'd1, 4'hB, 4'h0, 0, 4'hB, 0, 0);
        add(1, 1, 3'd5, 4'h0, 4'h0, 0, 4'h6, 0, 1);
        add(1, 1, 3'd0, 4'h0, 4'h0, 0, 4'h6, 0, 1);
        add(1, 1, 3'd6, 4'h0, 4'h0, 1, 4'hB, 0, 0);
        // enable low drops Carry and holds Q
        add(1, 1, 3'd1, 4'hF, 4'h0, 0, 4'hF, 0, 0);
        add(1, 1, 3'd3, 4'h0, 4'h0, 0, 4'h0, 1, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 3'd3, 4'h0, 4'h0, 0, 4'h0, 0, 0);
        // clear goes to 0, not RESET_VAL
        add(1, 1, 3'd1, 4'h3, 4'h0, 0, 4'h3, 0, 0);
        add(1, 1, 3'd7, 4'h0, 4'h0, 0, 4'h0, 0, 0);
        // reset mid-count
        add(1, 1, 3'd1, 4'h9, 4'h0, 0, 4'h9, 0, 0);
        add(0, 1, 3'd3, 4'h0, 4'h0, 0, 4'h5, 0, 0);

        #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].mode,
                  tbl[i].d, tbl[i].t, tbl[i].ser);
            step();
            check($sformatf("tbl%0d_q", i), Q, tbl[i].q);
            check($sformatf("tbl%0d_qinv", i), Q_inv, ~tbl[i].q & 4'hF);
            check($sformatf("tbl%0d_carry", i), Carry, tbl[i].carry);
            check($sformatf("tbl%0d_serout", i), Ser_out, tbl[i].so);
        end

        // async-looking reset glitch between edges is ignored
        drive(1, 1, 3'd1, 4'h7, 4'h0, 0);
        step();
        drive(1, 1, 3'd0, 4'h0, 4'h0, 0);
        #200 Reset_n = 1'b0;
        #100 Reset_n = 1'b1;
        step();
        check("glitch_q", Q, 4'h7);

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                  3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                  1'($urandom));
            step();
            check($sformatf("rnd%0d_q", i), Q, qm);
            check($sformatf("rnd%0d_qinv", i), Q_inv, 15 - qm);
            check($sformatf("rnd%0d_carry", i), Carry, cm);
            check($sformatf("rnd%0d_serout", i), Ser_out, sm);
        end

        // WIDTH=2 bit0 as T-trigger: Clock/2 square wave
        drive(1, 0, 3'd0, 4'h0, 4'h0, 0);
        step();
        check("w2_reset_q", q2, 0);
        rst2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("w2_q0_%0d", i), q2[0], i % 2);
            check($sformatf("w2_qinv0_%0d", i), q2_inv[0], 1 - i % 2);
            check($sformatf("w2_q1_%0d", i), q2[1], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
